// File: rtl/sha256_msg_sched_if.sv
// Message-word load handshake between a block source and sha256_msg_sched.
// The source drives data and valid; the scheduler answers with ready.
interface sha256_msg_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid_in;
  logic                  data_ready_out;

  modport master (output data_in, output data_valid_in, input data_ready_out);
  modport slave  (input data_in, input data_valid_in, output data_ready_out);
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule and round sequencer: loads 16 words, streams W[0..63],
// then steps the compression core through its 8-word digest readout.
//
// state  | meaning
// IDLE   | waiting for start_in, count held at 0
// LOAD   | accepting 16 message words, count = words accepted
// ROUND  | W_out = W[count], one round per cycle
// OUTPUT | core presents digest word count (0..7)
module sha256_msg_sched #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  sha256_msg_sched_if.slave     bus,
  output logic [DATA_WIDTH-1:0] W_out,
  output logic [2:0]            FSM_core_out,
  output logic [6:0]            core_count_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LOAD   = 3'b001,
    ST_ROUND  = 3'b011,
    ST_OUTPUT = 3'b100
  } state_t;

  state_t                state, state_nxt;
  logic [6:0]            count, count_nxt;
  logic                  done_nxt;
  logic                  load_shift, round_shift, accept;
  logic [DATA_WIDTH-1:0] w [16];
  logic [DATA_WIDTH-1:0] w_new;

  function automatic logic [DATA_WIDTH-1:0] sig0(input logic [DATA_WIDTH-1:0] x);
    return {x[6:0], x[DATA_WIDTH-1:7]} ^ {x[17:0], x[DATA_WIDTH-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sig1(input logic [DATA_WIDTH-1:0] x);
    return {x[16:0], x[DATA_WIDTH-1:17]} ^ {x[18:0], x[DATA_WIDTH-1:19]} ^ (x >> 10);
  endfunction

  assign bus.data_ready_out = (state == ST_LOAD);
  assign accept             = bus.data_valid_in & bus.data_ready_out;
  assign w_new              = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    load_shift  = 1'b0;
    round_shift = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (start_in) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          load_shift = 1'b1;
          if (count == 7'd15) begin
            state_nxt = ST_ROUND;
            count_nxt = '0;
          end else begin
            count_nxt = count + 7'd1;
          end
        end
      end
      ST_ROUND: begin
        round_shift = 1'b1;
        if (count == 7'd63) begin
          state_nxt = ST_OUTPUT;
          count_nxt = '0;
        end else begin
          count_nxt = count + 7'd1;
        end
      end
      ST_OUTPUT: begin
        if (count == 7'd7) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count + 7'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      done_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      done_out <= done_nxt;
    end
  end

  // Loading and rounds share one shift path; only the word entering w[15] differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load_shift || round_shift) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= load_shift ? bus.data_in : w_new;
    end
  end

  assign W_out          = w[0];
  assign FSM_core_out   = state;
  assign core_count_out = count;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc" and a second pattern, gapped loads,
// ignored start/valid noise, back-to-back blocks and a mid-round reset.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic [31:0] W_out;
  logic [2:0]  FSM_core_out;
  logic [6:0]  core_count_out;
  logic        done_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  sha256_msg_sched_if #(.DATA_WIDTH(32)) bus ();

  sha256_msg_sched #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .bus            (bus),
    .W_out          (W_out),
    .FSM_core_out   (FSM_core_out),
    .core_count_out (core_count_out),
    .done_out       (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule in the textbook array form W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
  task automatic build_model();
    logic [31:0] a, b;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        exp_w[t] = msg[t];
      end else begin
        a = rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        b = rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        exp_w[t] = a + exp_w[t-7] + b + exp_w[t-16];
      end
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_pattern2();
    for (int i = 0; i < 16; i++) msg[i] = 32'h01234567 * (i + 1) ^ 32'ha5a5_0000;
    build_model();
  endtask

  task automatic do_start();
    @(negedge clk);
    start_in = 1'b1;
    chk("start_idle_state", 32'(FSM_core_out), 32'h0);
    chk("start_idle_ready", 32'(bus.data_ready_out), 32'h0);
  endtask

  task automatic load_block(input bit gap);
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        @(negedge clk);
        start_in = 1'b0;
        bus.data_valid_in = 1'b0;
        bus.data_in = 32'hbad0bad0;
        chk("gap_state", 32'(FSM_core_out), 32'h1);
        chk("gap_count_hold", 32'(core_count_out), 32'(i));
      end
      @(negedge clk);
      start_in = 1'b0;
      bus.data_valid_in = 1'b1;
      bus.data_in = msg[i];
      chk("load_state", 32'(FSM_core_out), 32'h1);
      chk("load_count", 32'(core_count_out), 32'(i));
      chk("load_ready", 32'(bus.data_ready_out), 32'h1);
      chk("load_done_low", 32'(done_out), 32'h0);
    end
  endtask

  // Returns early after asserting rst at round stop_at and checking the reset state.
  task automatic run_rounds(input bit abc, input int stop_at, input bit noise);
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      bus.data_valid_in = noise && (t % 2 == 1);
      bus.data_in = 32'hffffffff;
      start_in = noise && (t % 8 == 2);
      chk("round_state", 32'(FSM_core_out), 32'h3);
      chk("round_count", 32'(core_count_out), 32'(t));
      chk("round_w", W_out, exp_w[t]);
      chk("round_ready", 32'(bus.data_ready_out), 32'h0);
      chk("round_done_low", 32'(done_out), 32'h0);
      if (abc) begin
        case (t)
          0:  chk("abc_w0", W_out, 32'h61626380);
          15: chk("abc_w15", W_out, 32'h00000018);
          16: chk("abc_w16", W_out, 32'h61626380);
          17: chk("abc_w17", W_out, 32'h000f0000);
          default: ;
        endcase
      end
      if (t == stop_at) begin
        rst = 1'b1;
        start_in = 1'b0;
        bus.data_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", 32'(FSM_core_out), 32'h0);
        chk("midrst_count", 32'(core_count_out), 32'h0);
        chk("midrst_ready", 32'(bus.data_ready_out), 32'h0);
        chk("midrst_w", W_out, 32'h0);
        chk("midrst_done", 32'(done_out), 32'h0);
        return;
      end
    end
  endtask

  task automatic run_output(input bit hold_start);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_in = hold_start || (k == 3);
      bus.data_valid_in = (k == 5);
      chk("out_state", 32'(FSM_core_out), 32'h4);
      chk("out_count", 32'(core_count_out), 32'(k));
      chk("out_done_low", 32'(done_out), 32'h0);
    end
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    chk("done_state", 32'(FSM_core_out), 32'h0);
    chk("done_pulse", 32'(done_out), 32'h1);
    chk("done_count", 32'(core_count_out), 32'h0);
    chk("done_ready", 32'(bus.data_ready_out), 32'h0);
    if (!hold_start) begin
      @(negedge clk);
      chk("after_done_low", 32'(done_out), 32'h0);
      chk("after_done_idle", 32'(FSM_core_out), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    bus.data_valid_in = 1'b0;
    bus.data_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(FSM_core_out), 32'h0);
    chk("rst_count", 32'(core_count_out), 32'h0);
    chk("rst_ready", 32'(bus.data_ready_out), 32'h0);
    chk("rst_w", W_out, 32'h0);
    chk("rst_done", 32'(done_out), 32'h0);
    rst = 1'b0;

    // valid while idle must not start or load anything
    @(negedge clk);
    bus.data_valid_in = 1'b1;
    bus.data_in = 32'hdeadbeef;
    chk("idle_valid_state", 32'(FSM_core_out), 32'h0);
    @(negedge clk);
    chk("idle_valid_state2", 32'(FSM_core_out), 32'h0);
    chk("idle_valid_ready", 32'(bus.data_ready_out), 32'h0);
    chk("idle_valid_w", W_out, 32'h0);
    bus.data_valid_in = 1'b0;

    set_abc();
    do_start();
    load_block(1'b0);
    run_rounds(1'b1, -1, 1'b0);
    run_output(1'b0);

    // gapped load, noisy rounds, start held so the next block follows immediately
    do_start();
    load_block(1'b1);
    run_rounds(1'b1, -1, 1'b1);
    run_output(1'b1);

    set_pattern2();
    load_block(1'b0);
    run_rounds(1'b0, -1, 1'b0);
    run_output(1'b0);

    set_abc();
    do_start();
    load_block(1'b0);
    run_rounds(1'b1, 30, 1'b0);

    do_start();
    load_block(1'b0);
    run_rounds(1'b1, -1, 1'b0);
    run_output(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
